// File: rtl/mod_counter_if.sv
// Count bus for mod_counter: the registered count value and its terminal-count decode.
// The counter drives the master side; consumers (dividers, slot logic) take the slave side.
interface mod_counter_if #(
    parameter int N = 10
);
    logic [N-1:0] mod_cntr;
    logic         tc;

    modport master (
        output mod_cntr,
        output tc
    );

    modport slave (
        input mod_cntr,
        input tc
    );
endinterface

// File: rtl/mod_counter.sv
// Free-running modulo-N counter with terminal-count decode.
// Reset asserts asynchronously; its release passes through a 2-flop synchroniser.
module mod_counter #(
    parameter int N = 10
) (
    input  logic          clk,
    input  logic          rst,
    mod_counter_if.master bus
);

    localparam logic [N-1:0] LAST = N'(N - 1);
    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [N-1:0] ZERO = '0;

    if (N < 2) begin : g_bad_n
        $fatal(1, "mod_counter: N must be at least 2");
    end

    logic [1:0]   rel_sync_q;
    logic [1:0]   rel_sync_d;
    logic         run;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // Release synchroniser: shifts in ones once rst goes high; cleared instantly by rst low.
    always_comb begin
        rel_sync_d = {rel_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_sync_q <= 2'b00;
        end else begin
            rel_sync_q <= rel_sync_d;
        end
    end

    assign run = rel_sync_q[1];

    // Anything at or past N-1 (including unreachable upset values) wraps to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            if (cnt_q >= LAST) begin
                cnt_d = ZERO;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.mod_cntr = cnt_q;
    assign bus.tc       = (cnt_q == LAST);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: N=10, N=2 and N=16 instances share clock and reset.
// Expected counts come from a counting-edge index k, with two release-synchroniser edges.
module tb_mod_counter;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    int sync_edges;
    int k;

    mod_counter_if #(.N(10)) bus10 ();
    mod_counter_if #(.N(2))  bus2  ();
    mod_counter_if #(.N(16)) bus16 ();

    mod_counter #(.N(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
    mod_counter #(.N(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
    mod_counter #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; sample 1 time unit later and advance the reference index.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            if (sync_edges < 2) sync_edges++;
            else k++;
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        sync_edges = 0;
        k = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus10.mod_cntr !== 10'd0 || bus10.tc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold10 cyc=%0d cnt=%0d tc=%b want cnt=0 tc=0", i, bus10.mod_cntr, bus10.tc);
            end
            n_checks++;
            if (bus2.mod_cntr !== 2'd0 || bus16.mod_cntr !== 16'd0 || bus2.tc !== 1'b0 || bus16.tc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_2_16 cyc=%0d cnt2=%0d cnt16=%0d want 0", i, bus2.mod_cntr, bus16.mod_cntr);
            end
        end
    endtask

    task automatic test_release_latency();
        release_rst();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus10.mod_cntr !== 10'd0) begin
                n_fail++;
                $display("FAIL release_sync edge=%0d cnt=%0d want 0", i + 1, bus10.mod_cntr);
            end
        end
        step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd1) begin
            n_fail++;
            $display("FAIL first_increment cnt=%0d want 1", bus10.mod_cntr);
        end
    endtask

    task automatic test_count();
        int tc_seen;
        tc_seen = 0;
        // k is 1 here; run to k = 40
        for (int i = 0; i < 39; i++) begin
            step();
            n_checks++;
            if (bus10.mod_cntr !== 10'(k % 10)) begin
                n_fail++;
                $display("FAIL count10 k=%0d cnt=%0d want %0d", k, bus10.mod_cntr, k % 10);
            end
            n_checks++;
            if (bus10.tc !== ((k % 10) == 9)) begin
                n_fail++;
                $display("FAIL tc10 k=%0d tc=%b want %b", k, bus10.tc, (k % 10) == 9);
            end
            if (bus10.tc === 1'b1) tc_seen++;
        end
        n_checks++;
        if (tc_seen !== 4) begin
            n_fail++;
            $display("FAIL tc_rate count=%0d want 4", tc_seen);
        end
    endtask

    task automatic test_wrap();
        while ((k % 10) != 9) step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd9 || bus10.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_at9 cnt=%0d tc=%b want cnt=9 tc=1", bus10.mod_cntr, bus10.tc);
        end
        step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd0 || bus10.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_to0 cnt=%0d tc=%b want cnt=0 tc=0", bus10.mod_cntr, bus10.tc);
        end
    endtask

    task automatic test_other_n();
        for (int i = 0; i < 36; i++) begin
            step();
            n_checks++;
            if (bus2.mod_cntr !== 2'(k % 2) || bus2.tc !== ((k % 2) == 1)) begin
                n_fail++;
                $display("FAIL count2 k=%0d cnt=%0d tc=%b want %0d", k, bus2.mod_cntr, bus2.tc, k % 2);
            end
            n_checks++;
            if (bus16.mod_cntr !== 16'(k % 16) || bus16.tc !== ((k % 16) == 15)) begin
                n_fail++;
                $display("FAIL count16 k=%0d cnt=%0d tc=%b want %0d", k, bus16.mod_cntr, bus16.tc, k % 16);
            end
            n_checks++;
            if (bus2.mod_cntr >= 2'd2 || bus16.mod_cntr >= 16'd16) begin
                n_fail++;
                $display("FAIL range cnt2=%0d cnt16=%0d want below N", bus2.mod_cntr, bus16.mod_cntr);
            end
        end
    endtask

    task automatic test_reset_mid();
        while ((k % 10) != 6) step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd6) begin
            n_fail++;
            $display("FAIL pre_reset cnt=%0d want 6", bus10.mod_cntr);
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus10.mod_cntr !== 10'd0 || bus10.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear cnt=%0d tc=%b want cnt=0 tc=0", bus10.mod_cntr, bus10.tc);
        end
        step();
        step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_held cnt=%0d want 0", bus10.mod_cntr);
        end
        release_rst();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus10.mod_cntr !== 10'(k % 10)) begin
                n_fail++;
                $display("FAIL restart k=%0d cnt=%0d want %0d", k, bus10.mod_cntr, k % 10);
            end
        end
    endtask

    task automatic test_illegal();
        n_checks++;
        if (bus10.mod_cntr !== 10'd3) begin
            n_fail++;
            $display("FAIL pre_illegal cnt=%0d want 3", bus10.mod_cntr);
        end
        #1;
        force dut10.cnt_q = 10'd12;
        #1;
        n_checks++;
        if (bus10.mod_cntr !== 10'd12 || bus10.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_hold cnt=%0d tc=%b want cnt=12 tc=0", bus10.mod_cntr, bus10.tc);
        end
        release dut10.cnt_q;
        step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd0) begin
            n_fail++;
            $display("FAIL illegal_recover cnt=%0d want 0", bus10.mod_cntr);
        end
        step();
        n_checks++;
        if (bus10.mod_cntr !== 10'd1) begin
            n_fail++;
            $display("FAIL after_recover cnt=%0d want 1", bus10.mod_cntr);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        sync_edges = 0;
        k          = 0;
        rst        = 1'b0;
        #1;
        n_checks++;
        if (bus10.mod_cntr !== 10'd0 || bus10.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_clk cnt=%0d tc=%b want cnt=0 tc=0", bus10.mod_cntr, bus10.tc);
        end
        test_reset();
        test_release_latency();
        test_count();
        test_wrap();
        test_other_n();
        test_reset_mid();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
